// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 32-bit CPU data path.
// Sequences each instruction FETCH -> DECODE -> [MEMRD] -> EXEC and decodes
// every data-path strobe, mux select and ALU op from state, IR and the
// registered ALU flags.
module control_unit #(
  parameter logic [2:0] ALU_ADD = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic        wen,
  output logic        en,
  output logic        clr_A,
  output logic        clr_B,
  output logic        clr_C,
  output logic        clr_Z,
  output logic        clr_PC,
  output logic        clr_IR,
  output logic        ld_A,
  output logic        ld_B,
  output logic        ld_C,
  output logic        ld_Z,
  output logic        ld_PC,
  output logic        ld_IR,
  output logic        inc_PC,
  output logic [1:0]  data_mux,
  output logic [1:0]  im_mux2,
  output logic        im_mux1,
  output logic        a_mux,
  output logic        b_mux,
  output logic        reg_mux,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALUOP_W = 3;

  // Opcodes (ir[31:28])
  localparam logic [OP_W-1:0] OP_LDAI = 4'h0;
  localparam logic [OP_W-1:0] OP_LDBI = 4'h1;
  localparam logic [OP_W-1:0] OP_LDA  = 4'h2;
  localparam logic [OP_W-1:0] OP_LDB  = 4'h3;
  localparam logic [OP_W-1:0] OP_STA  = 4'h4;
  localparam logic [OP_W-1:0] OP_STB  = 4'h5;
  localparam logic [OP_W-1:0] OP_ALUR = 4'h6;
  localparam logic [OP_W-1:0] OP_ALUI = 4'h7;
  localparam logic [OP_W-1:0] OP_INCA = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
  localparam logic [OP_W-1:0] OP_JC   = 4'hB;
  localparam logic [OP_W-1:0] OP_CLRA = 4'hC;
  localparam logic [OP_W-1:0] OP_CLRB = 4'hD;
  localparam logic [OP_W-1:0] OP_NOP  = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // Data bus sources
  localparam logic [1:0] DBUS_IN  = 2'b00;
  localparam logic [1:0] DBUS_MEM = 2'b01;
  localparam logic [1:0] DBUS_ALU = 2'b10;

  // ALU operand B sources
  localparam logic [1:0] OPB_REG   = 2'b00;
  localparam logic [1:0] OPB_IMM   = 2'b01;
  localparam logic [1:0] OPB_CONST = 2'b10;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                flag_c;
  logic                flag_z;
  logic [OP_W-1:0]     opcode;
  logic [ALUOP_W-1:0]  ir_alu_op;
  logic                is_alu_instr;

  // Memory address and immediate bits are consumed by the data path only.
  logic unused_ir;
  assign unused_ir = ^ir[24:0];

  assign opcode       = ir[31:28];
  assign ir_alu_op    = ir[27:25];
  assign is_alu_instr = (opcode == OP_ALUR) || (opcode == OP_ALUI) || (opcode == OP_INCA);
  assign state        = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Carry/zero flags: captured only when an ALU instruction executes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (state_q == ST_EXEC && is_alu_instr) begin
      flag_c <= alu_c;
      flag_z <= alu_z;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = ST_RST;
    wen      = 1'b0;
    en       = 1'b0;
    clr_A    = 1'b0;
    clr_B    = 1'b0;
    clr_C    = 1'b0;
    clr_Z    = 1'b0;
    clr_PC   = 1'b0;
    clr_IR   = 1'b0;
    ld_A     = 1'b0;
    ld_B     = 1'b0;
    ld_C     = 1'b0;
    ld_Z     = 1'b0;
    ld_PC    = 1'b0;
    ld_IR    = 1'b0;
    inc_PC   = 1'b0;
    data_mux = DBUS_IN;
    im_mux2  = OPB_REG;
    im_mux1  = 1'b0;
    a_mux    = 1'b0;
    b_mux    = 1'b0;
    reg_mux  = 1'b0;
    alu_op   = '0;
    halted   = 1'b0;

    case (state_q)
      ST_RST: begin
        clr_A   = 1'b1;
        clr_B   = 1'b1;
        clr_C   = 1'b1;
        clr_Z   = 1'b1;
        clr_PC  = 1'b1;
        clr_IR  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        data_mux = DBUS_IN;
        ld_IR    = 1'b1;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        inc_PC = 1'b1;
        if (opcode == OP_LDA || opcode == OP_LDB) begin
          state_d = ST_MEMRD;
        end else if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end

      // Address mem[ir[7:0]] one cycle ahead so read data is valid in EXEC
      ST_MEMRD: begin
        en      = 1'b1;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_LDAI: begin
            a_mux = 1'b1;
            ld_A  = 1'b1;
          end
          OP_LDBI: begin
            b_mux = 1'b1;
            ld_B  = 1'b1;
          end
          OP_LDA: begin
            en       = 1'b1;
            data_mux = DBUS_MEM;
            ld_A     = 1'b1;
          end
          OP_LDB: begin
            en       = 1'b1;
            data_mux = DBUS_MEM;
            ld_B     = 1'b1;
          end
          OP_STA: begin
            en      = 1'b1;
            wen     = 1'b1;
            reg_mux = 1'b0;
          end
          OP_STB: begin
            en      = 1'b1;
            wen     = 1'b1;
            reg_mux = 1'b1;
          end
          OP_ALUR, OP_ALUI, OP_INCA: begin
            data_mux = DBUS_ALU;
            ld_A     = 1'b1;
            ld_C     = 1'b1;
            ld_Z     = 1'b1;
            if (opcode == OP_INCA) begin
              im_mux2 = OPB_CONST;
              alu_op  = ALU_ADD;
            end else begin
              im_mux2 = (opcode == OP_ALUI) ? OPB_IMM : OPB_REG;
              alu_op  = ir_alu_op;
            end
          end
          OP_JMP:  ld_PC = 1'b1;
          OP_JZ:   ld_PC = flag_z;
          OP_JC:   ld_PC = flag_c;
          OP_CLRA: clr_A = 1'b1;
          OP_CLRB: clr_B = 1'b1;
          OP_NOP:  ;
          default: ;
        endcase
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a random
// instruction stream, compared cycle by cycle against an instruction-level model.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ir;
  logic        alu_c;
  logic        alu_z;
  logic        wen, en;
  logic        clr_A, clr_B, clr_C, clr_Z, clr_PC, clr_IR;
  logic        ld_A, ld_B, ld_C, ld_Z, ld_PC, ld_IR, inc_PC;
  logic [1:0]  data_mux, im_mux2;
  logic        im_mux1, a_mux, b_mux, reg_mux;
  logic [2:0]  alu_op;
  logic        halted;
  logic [2:0]  state;

  typedef struct packed {
    logic       wen;
    logic       en;
    logic       clr_A;
    logic       clr_B;
    logic       clr_C;
    logic       clr_Z;
    logic       clr_PC;
    logic       clr_IR;
    logic       ld_A;
    logic       ld_B;
    logic       ld_C;
    logic       ld_Z;
    logic       ld_PC;
    logic       ld_IR;
    logic       inc_PC;
    logic [1:0] data_mux;
    logic [1:0] im_mux2;
    logic       im_mux1;
    logic       a_mux;
    logic       b_mux;
    logic       reg_mux;
    logic [2:0] alu_op;
    logic       halted;
    logic [2:0] state;
  } outs_t;

  outs_t got;
  assign got = {wen, en, clr_A, clr_B, clr_C, clr_Z, clr_PC, clr_IR,
                ld_A, ld_B, ld_C, ld_Z, ld_PC, ld_IR, inc_PC,
                data_mux, im_mux2, im_mux1, a_mux, b_mux, reg_mux,
                alu_op, halted, state};

  int checks;
  int failures;
  int force_z;   // -1: random alu_z, else forced value
  bit mfc, mfz;  // model of the architectural carry/zero flags

  control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .alu_c(alu_c), .alu_z(alu_z),
    .wen(wen), .en(en),
    .clr_A(clr_A), .clr_B(clr_B), .clr_C(clr_C), .clr_Z(clr_Z),
    .clr_PC(clr_PC), .clr_IR(clr_IR),
    .ld_A(ld_A), .ld_B(ld_B), .ld_C(ld_C), .ld_Z(ld_Z), .ld_PC(ld_PC),
    .ld_IR(ld_IR), .inc_PC(inc_PC),
    .data_mux(data_mux), .im_mux2(im_mux2), .im_mux1(im_mux1),
    .a_mux(a_mux), .b_mux(b_mux), .reg_mux(reg_mux),
    .alu_op(alu_op), .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for a given phase (state code) of an instruction
  function automatic outs_t expect_out(input int ph, input logic [31:0] instr,
                                       input bit fz, input bit fc);
    outs_t o;
    logic [3:0] op;
    o = '0;
    op = instr[31:28];
    o.state = 3'(ph);
    case (ph)
      0: begin
        o.clr_A = 1'b1; o.clr_B = 1'b1; o.clr_C = 1'b1;
        o.clr_Z = 1'b1; o.clr_PC = 1'b1; o.clr_IR = 1'b1;
      end
      1: o.ld_IR = 1'b1;
      2: o.inc_PC = 1'b1;
      3: o.en = 1'b1;
      5: o.halted = 1'b1;
      4: begin
        if (op == 4'h0) begin o.a_mux = 1'b1; o.ld_A = 1'b1; end
        if (op == 4'h1) begin o.b_mux = 1'b1; o.ld_B = 1'b1; end
        if (op == 4'h2 || op == 4'h3) begin
          o.en = 1'b1; o.data_mux = 2'b01;
          o.ld_A = (op == 4'h2); o.ld_B = (op == 4'h3);
        end
        if (op == 4'h4 || op == 4'h5) begin
          o.en = 1'b1; o.wen = 1'b1; o.reg_mux = (op == 4'h5);
        end
        if (op >= 4'h6 && op <= 4'h8) begin
          o.data_mux = 2'b10; o.ld_A = 1'b1; o.ld_C = 1'b1; o.ld_Z = 1'b1;
          o.alu_op  = (op == 4'h8) ? 3'b010 : instr[27:25];
          o.im_mux2 = (op == 4'h6) ? 2'b00 : ((op == 4'h7) ? 2'b01 : 2'b10);
        end
        if (op == 4'h9) o.ld_PC = 1'b1;
        if (op == 4'hA) o.ld_PC = fz;
        if (op == 4'hB) o.ld_PC = fc;
        if (op == 4'hC) o.clr_A = 1'b1;
        if (op == 4'hD) o.clr_B = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input outs_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    checks++;
    assert (!(got.wen && !got.en)) else begin
      failures++;
      $error("FAIL %s_wen_en observed wen=%b en=%b required en=1", tag, got.wen, got.en);
    end
  endtask

  // Run one instruction from its FETCH cycle; optionally reset during EXEC
  task automatic run_instr(input logic [31:0] instr, input bit abort_exec);
    logic [3:0] op;
    int ph[$];
    op = instr[31:28];
    ph.push_back(1);
    ph.push_back(2);
    if (op == 4'h2 || op == 4'h3) ph.push_back(3);
    if (op != 4'hF) ph.push_back(4);
    foreach (ph[k]) begin
      ir    = instr;
      alu_c = 1'($urandom);
      alu_z = (force_z >= 0) ? 1'(force_z) : 1'($urandom);
      #1;
      chk($sformatf("op%0h_ph%0d", op, ph[k]), expect_out(ph[k], instr, mfz, mfc));
      if (ph[k] == 4 && abort_exec) begin
        reset = 1'b1;
        mfz = 1'b0;
        mfc = 1'b0;
        #1;
        chk("rst_async", expect_out(0, instr, mfz, mfc));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_hold", expect_out(0, instr, mfz, mfc));
        reset = 1'b0;
        #1;
        chk("rst_release", expect_out(0, instr, mfz, mfc));
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(posedge clk);
      if (ph[k] == 4 && op >= 4'h6 && op <= 4'h8) begin
        mfc = alu_c;
        mfz = alu_z;
      end
      @(negedge clk);
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 20; i++) begin
        #1;
        chk($sformatf("halt_%0d", i), expect_out(5, instr, mfz, mfc));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    checks   = 0;
    failures = 0;
    force_z  = -1;
    mfc      = 1'b0;
    mfz      = 1'b0;
    reset    = 1'b1;
    ir       = '0;
    alu_c    = 1'b0;
    alu_z    = 1'b0;

    // Power-on reset
    @(negedge clk);
    #1;
    chk("reset", expect_out(0, ir, mfz, mfc));
    reset = 1'b0;
    #1;
    chk("reset_release", expect_out(0, ir, mfz, mfc));
    @(posedge clk);
    @(negedge clk);

    // Directed instructions
    run_instr(32'h0000_0005, 1'b0);  // LDAI
    run_instr(32'h2000_0010, 1'b0);  // LDA
    force_z = 1;
    run_instr(32'h6400_0000, 1'b0);  // ALUR, zero flag set
    force_z = -1;
    run_instr(32'hA000_0020, 1'b0);  // JZ taken
    force_z = 0;
    run_instr(32'h6400_0000, 1'b0);  // ALUR, zero flag clear
    force_z = -1;
    run_instr(32'hA000_0020, 1'b0);  // JZ not taken
    run_instr(32'h4000_0003, 1'b0);  // STA
    run_instr(32'h5000_0007, 1'b0);  // STB
    run_instr(32'h3000_0044, 1'b0);  // LDB
    run_instr(32'h8000_0000, 1'b0);  // INCA

    // Reset during EXEC of an ALU op: flag update must be dropped
    force_z = 1;
    run_instr(32'h6400_0000, 1'b1);
    force_z = -1;
    run_instr(32'hA000_0020, 1'b0);  // JZ sees cleared flag

    // Random instruction stream (no HALT), occasional mid-EXEC reset
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      r[31:28] = 4'($urandom_range(0, 14));
      run_instr(r, ($urandom_range(0, 39) == 0));
    end

    // HALT holds until reset
    run_instr(32'hF000_0000, 1'b0);
    reset = 1'b1;
    #1;
    chk("halt_reset", expect_out(0, ir, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
